// File: rtl/alu_result_writeback_pkg.sv
// Shared constants for the ALU result writeback stage: word width, ALU control codes,
// register-file write-target encodings and the writeback FSM state type.
package alu_result_writeback_pkg;

  localparam int unsigned WIDTH = 32;

  localparam logic [4:0] OP_AND = 5'b00001;
  localparam logic [4:0] OP_OR  = 5'b00010;
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_SHR = 5'b00101;
  localparam logic [4:0] OP_SHL = 5'b00110;
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
  localparam logic [4:0] OP_NOP = 5'b11111;

  localparam logic [1:0] WB_RD = 2'd0;
  localparam logic [1:0] WB_LO = 2'd1;
  localparam logic [1:0] WB_HI = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StWb1,
    StWb2,
    StDone
  } wb_state_e;

  // MUL/DIV produce a full 64-bit result that lands in LO then HI.
  function automatic logic is_two_write(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_result_writeback_z_reg64.sv
// Split Z register (ZHI/ZLO) with load enable and synchronous active-low clear.
module alu_result_writeback_z_reg64 #(
  parameter int unsigned Width = 32
) (
  input  logic               clk_i,
  input  logic               clr_ni,
  input  logic               load_i,
  input  logic [2*Width-1:0] d_i,
  output logic [Width-1:0]   z_hi_o,
  output logic [Width-1:0]   z_lo_o
);

  logic [Width-1:0] z_hi_q, z_hi_d;
  logic [Width-1:0] z_lo_q, z_lo_d;

  always_comb begin
    z_hi_d = z_hi_q;
    z_lo_d = z_lo_q;
    if (load_i) begin
      z_hi_d = d_i[2*Width-1:Width];
      z_lo_d = d_i[Width-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      z_hi_q <= '0;
      z_lo_q <= '0;
    end else begin
      z_hi_q <= z_hi_d;
      z_lo_q <= z_lo_d;
    end
  end

  assign z_hi_o = z_hi_q;
  assign z_lo_o = z_lo_q;

endmodule

// File: rtl/alu_result_writeback.sv
// Captures the 64-bit ALU result into Z and sequences one (ALU op) or two (MUL/DIV)
// register-file writes over a valid/ready port; also produces the N/Z branch flags.
module alu_result_writeback
  import alu_result_writeback_pkg::*;
(
  input  logic               clk_i,
  input  logic               clr_ni,
  input  logic               start_i,
  input  logic [4:0]         alu_ctrl_i,
  input  logic [2*WIDTH-1:0] alu_result_i,
  input  logic               wb_ready_i,
  output logic               wb_valid_o,
  output logic [1:0]         wb_sel_o,
  output logic [WIDTH-1:0]   wb_data_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   z_hi_o,
  output logic [WIDTH-1:0]   z_lo_o,
  output logic               flag_n_o,
  output logic               flag_z_o,
  output logic               overrun_o
);

  wb_state_e  state_q;
  logic [4:0] op_q;
  logic       wb_valid_q;
  logic [1:0] wb_sel_q;
  logic       busy_q;
  logic       done_q;
  logic       flag_n_q;
  logic       flag_z_q;
  logic       overrun_q;
  logic       capture;
  logic [WIDTH-1:0] z_hi, z_lo;

  assign capture = (state_q == StIdle) && start_i;

  alu_result_writeback_z_reg64 #(
    .Width (WIDTH)
  ) u_z_reg (
    .clk_i  (clk_i),
    .clr_ni (clr_ni),
    .load_i (capture),
    .d_i    (alu_result_i),
    .z_hi_o (z_hi),
    .z_lo_o (z_lo)
  );

  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      state_q    <= StIdle;
      op_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_sel_q   <= WB_RD;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      flag_n_q   <= 1'b0;
      flag_z_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (start_i && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            op_q     <= alu_ctrl_i;
            flag_n_q <= alu_result_i[WIDTH-1];
            flag_z_q <= (alu_result_i[WIDTH-1:0] == '0);
            busy_q   <= 1'b1;
            if (alu_ctrl_i == OP_NOP) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q    <= StWb1;
              wb_valid_q <= 1'b1;
              wb_sel_q   <= is_two_write(alu_ctrl_i) ? WB_LO : WB_RD;
            end
          end
        end
        StWb1: begin
          if (wb_ready_i) begin
            if (is_two_write(op_q)) begin
              state_q  <= StWb2;
              wb_sel_q <= WB_HI;
            end else begin
              state_q    <= StDone;
              wb_valid_q <= 1'b0;
              wb_sel_q   <= WB_RD;
              done_q     <= 1'b1;
            end
          end
        end
        StWb2: begin
          if (wb_ready_i) begin
            state_q    <= StDone;
            wb_valid_q <= 1'b0;
            wb_sel_q   <= WB_RD;
            done_q     <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wb_valid_o = wb_valid_q;
  assign wb_sel_o   = wb_sel_q;
  assign wb_data_o  = !wb_valid_q ? '0 : ((state_q == StWb2) ? z_hi : z_lo);
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign z_hi_o     = z_hi;
  assign z_lo_o     = z_lo;
  assign flag_n_o   = flag_n_q;
  assign flag_z_o   = flag_z_q;
  assign overrun_o  = overrun_q;

endmodule
